led_pulse_stretcher: RTL and testbench
======================================

Name: led_pulse_stretcher

Overview:
Output-side counterpart to input switch conditioning. Converts single-cycle internal events into human-visible LED pulses with a guaranteed minimum on-time and off-time. Events that arrive during a pulse are queued in a saturating pending counter, so no event is lost until the counter saturates. Sits between core logic (event strobes) and board LED pins.

Parameters:
DVSR, 100000, clock cycles per base tick (1 ms at 100 MHz); must be >= 2
ON_TICKS, 50, base ticks the LED is held high per pulse; >= 1
OFF_TICKS, 50, base ticks the LED is held low after each pulse; >= 1
PEND_W, 4, width of the pending-event counter; max queued = 2^PEND_W-1

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
event_in  input  1  event request; a rising edge counts as one event
ovf_clr  input  1  synchronous clear of the overflow flag
led  output  1  stretched pulse output
busy  output  1  high whenever state is not IDLE
pending  output  PEND_W  queued events not yet displayed
overflow  output  1  sticky; set when an event is dropped at saturation

Behaviour:
- Reset (reset==0 at a rising clk edge): state IDLE, led=0, busy=0, pending=0, overflow=0, tick prescaler=0, tick counter=0, event_d=0. Reset takes priority over all other inputs, including mid-pulse.
- Edge detect: ev = event_in & ~event_d, with event_d registered. A level held high yields exactly one event. event_in high on the first cycle after reset release counts as an event.
- Base tick: prescaler counts 0..DVSR-1. tick=1 when the count equals DVSR-1, then the count wraps to 0. The prescaler and tick counter clear synchronously on every state entry.
- Outputs are Moore: led=(state==ON), busy=(state!=IDLE).
- States:
  - IDLE: on ev, go to ON. Pending is unchanged.
  - ON: count ticks. When tick arrives with tick_cnt==ON_TICKS-1, go to OFF.
  - OFF: count ticks. When tick arrives with tick_cnt==OFF_TICKS-1:
    - if pending>0 or ev in the same cycle, go to ON;
    - otherwise go to IDLE.
- Timing:
  - led rises in the first cycle after the edge that samples ev in IDLE (1-cycle latency).
  - The ON phase lasts exactly ON_TICKS*DVSR cycles; the OFF phase lasts exactly OFF_TICKS*DVSR cycles.
  - Back-to-back queued pulses therefore have a period of (ON_TICKS+OFF_TICKS)*DVSR cycles.
- Pending counter:
  - inc = ev while in ON or OFF, or ev in the OFF-exit cycle.
  - dec = OFF-to-ON transition.
  - In the OFF-exit cycle, an ev with pending==0 is consumed directly: go to ON, pending stays 0.
  - inc and dec in the same cycle: pending is unchanged.
  - inc at pending==2^PEND_W-1 without dec: pending holds and overflow is set.
- Overflow: ovf_clr clears it. If set and clear occur in the same cycle, set wins.
- Width rules: tick_cnt width = clog2(max(ON_TICKS,OFF_TICKS)). Prescaler width = clog2(DVSR). All compares are unsigned.

Decomposition:
- Shared package holds the state encoding localparams: IDLE=2'b00, ON=2'b01, OFF=2'b10. 2'b11 is illegal and recovers to IDLE.
- One sub-module, tick_gen:
  - parameter DVSR
  - ports clk, reset, clr, tick
  - synchronous active-low reset; clr has priority over counting
- The top level holds the FSM, tick counter, edge detector, pending counter and overflow logic.

Test Plan:
Bench parameters: DVSR=4, ON_TICKS=3, OFF_TICKS=2, PEND_W=2. This gives ON = 12 cycles and OFF = 8 cycles.
1. Single 1-cycle event_in pulse from IDLE -> led high exactly 12 cycles starting 1 cycle after sampling, low 8 cycles with busy=1, then busy=0 and pending=0.
2. event_in held high for 40 cycles -> exactly one pulse, pending stays 0.
3. Three events during the first ON phase -> pending reads 1,2,3; three further pulses follow back-to-back with a 20-cycle period, pending decrementing 2,1,0 at each OFF-to-ON edge.
4. Four events during one ON phase -> pending saturates at 3 and overflow=1. ovf_clr pulse clears overflow. ovf_clr asserted in the same cycle as a new dropped event -> overflow stays 1.
5. Event exactly in the OFF-exit cycle with pending=0 -> goes straight to ON, pending stays 0. Same with pending=1 -> pending stays 1 (inc and dec cancel).
6. reset=0 mid-ON (cycle 5 of pulse) with pending=2 -> next cycle led=0, busy=0, pending=0, overflow=0. A subsequent event produces a full 12-cycle pulse.

Source files
------------

// File: rtl/led_pulse_stretcher_pkg.sv
// rtl/led_pulse_stretcher_pkg.sv - shared state encoding and width helper for the LED pulse stretcher
package led_pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ON   = 2'b01,
    OFF  = 2'b10
  } state_e;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_pulse_stretcher_tick_gen.sv
// rtl/led_pulse_stretcher_tick_gen.sv - base tick prescaler, one-cycle tick every DVSR clocks
module led_pulse_stretcher_tick_gen
  import led_pulse_stretcher_pkg::*;
#(
  parameter int unsigned DVSR = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int unsigned W = cnt_width(DVSR);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == W'(DVSR - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_pulse_stretcher.sv
// rtl/led_pulse_stretcher.sv - stretches event strobes into LED pulses with min on/off time and a pending queue
module led_pulse_stretcher
  import led_pulse_stretcher_pkg::*;
#(
  parameter int unsigned DVSR      = 100000,
  parameter int unsigned ON_TICKS  = 50,
  parameter int unsigned OFF_TICKS = 50,
  parameter int unsigned PEND_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              event_in,
  input  logic              ovf_clr,
  output logic              led,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int unsigned MAX_TICKS = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int unsigned CW        = cnt_width(MAX_TICKS);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_e            state_q, state_d;
  logic [CW-1:0]     tcnt_q, tcnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              ev_prev_q, ev_prev_d;
  logic              ev, tick, entry, inc, dec, ovf_set;

  led_pulse_stretcher_tick_gen #(
    .DVSR(DVSR)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .clr  (entry),
    .tick (tick)
  );

  always_comb begin
    ev        = event_in & ~ev_prev_q;
    ev_prev_d = event_in;
    state_d   = state_q;
    case (state_q)
      IDLE: if (ev) state_d = ON;
      ON:   if (tick && tcnt_q == CW'(ON_TICKS - 1)) state_d = OFF;
      OFF: begin
        if (tick && tcnt_q == CW'(OFF_TICKS - 1)) begin
          state_d = ((pend_q != '0) || ev) ? ON : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Every state entry restarts both the prescaler and the tick count.
    entry  = (state_d != state_q);
    tcnt_d = tcnt_q;
    if (entry) begin
      tcnt_d = '0;
    end else if (tick) begin
      tcnt_d = tcnt_q + 1'b1;
    end

    // An event in the OFF-exit cycle with nothing queued cancels against the dequeue.
    inc     = ev & ((state_q == ON) || (state_q == OFF));
    dec     = (state_q == OFF) && (state_d == ON);
    pend_d  = pend_q;
    ovf_set = 1'b0;
    if (inc && !dec) begin
      if (pend_q == PEND_MAX) begin
        ovf_set = 1'b1;
      end else begin
        pend_d = pend_q + 1'b1;
      end
    end else if (dec && !inc) begin
      pend_d = pend_q - 1'b1;
    end
    ovf_d = ovf_set | (ovf_q & ~ovf_clr);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      tcnt_q    <= '0;
      pend_q    <= '0;
      ovf_q     <= 1'b0;
      ev_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      pend_q    <= pend_d;
      ovf_q     <= ovf_d;
      ev_prev_q <= ev_prev_d;
    end
  end

  assign led      = (state_q == ON);
  assign busy     = (state_q != IDLE);
  assign pending  = pend_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// tb/tb_led_pulse_stretcher.sv - directed and random checks of led_pulse_stretcher against a cycle-count model
module tb_led_pulse_stretcher;

  localparam int DVSR    = 4;
  localparam int ON_T    = 3;
  localparam int OFF_T   = 2;
  localparam int PW      = 2;
  localparam int ON_CYC  = ON_T * DVSR;
  localparam int OFF_CYC = OFF_T * DVSR;
  localparam int PMAX    = (1 << PW) - 1;
  localparam int P_IDLE  = 0;
  localparam int P_ON    = 1;
  localparam int P_OFF   = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          event_in = 1'b0;
  logic          ovf_clr = 1'b0;
  logic          led, busy, overflow;
  logic [PW-1:0] pending;

  int checks = 0;
  int failures = 0;
  int m_phase = P_IDLE;
  int m_rem = 0;
  int m_pend = 0;
  bit m_ovf = 1'b0;
  bit m_prev = 1'b0;
  int led_hi = 0;
  int led_rises = 0;
  bit led_last = 1'b0;

  led_pulse_stretcher #(
    .DVSR(DVSR), .ON_TICKS(ON_T), .OFF_TICKS(OFF_T), .PEND_W(PW)
  ) dut (
    .clk(clk), .reset(reset), .event_in(event_in), .ovf_clr(ovf_clr),
    .led(led), .busy(busy), .pending(pending), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Phase model: each phase is a fixed number of cycles counted down.
  task automatic model_edge();
    bit ev, inc, dec, set;
    if (!reset) begin
      m_phase = P_IDLE; m_rem = 0; m_pend = 0; m_ovf = 1'b0; m_prev = 1'b0;
    end else begin
      ev = event_in && !m_prev;
      m_prev = event_in;
      inc = ev && (m_phase != P_IDLE);
      dec = 1'b0;
      set = 1'b0;
      if (m_phase == P_IDLE) begin
        if (ev) begin m_phase = P_ON; m_rem = ON_CYC; end
      end else if (m_phase == P_ON) begin
        m_rem--;
        if (m_rem == 0) begin m_phase = P_OFF; m_rem = OFF_CYC; end
      end else begin
        m_rem--;
        if (m_rem == 0) begin
          if (m_pend > 0 || ev) begin dec = 1'b1; m_phase = P_ON; m_rem = ON_CYC; end
          else m_phase = P_IDLE;
        end
      end
      if (inc && !dec && m_pend == PMAX) set = 1'b1;
      else m_pend = m_pend + int'(inc) - int'(dec);
      m_ovf = set || (m_ovf && !ovf_clr);
    end
  endtask

  task automatic step(input logic rn, input logic ein, input logic clr);
    reset = rn; event_in = ein; ovf_clr = clr;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("led", 32'(led), 32'(m_phase == P_ON));
    chk("busy", 32'(busy), 32'(m_phase != P_IDLE));
    chk("pending", 32'(pending), 32'(m_pend));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (led === 1'b1) led_hi++;
    if (led === 1'b1 && !led_last) led_rises++;
    led_last = (led === 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    @(negedge clk);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_pending", 32'(pending), 32'd0);

    // Single short event
    led_hi = 0;
    step(1'b1, 1'b1, 1'b0);
    chk("t1_latency", 32'(led), 32'd1);
    idle(30);
    chk("t1_on_len", 32'(led_hi), 32'd12);
    chk("t1_idle", 32'(busy), 32'd0);

    // Held level gives one pulse
    led_rises = 0;
    repeat (40) step(1'b1, 1'b1, 1'b0);
    idle(30);
    chk("t2_one_pulse", 32'(led_rises), 32'd1);
    chk("t2_pending", 32'(pending), 32'd0);

    // Three queued events, back-to-back pulses
    led_rises = 0;
    step(1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      chk("t3_pending_up", 32'(pending), 32'(i));
    end
    idle(90);
    chk("t3_pulses", 32'(led_rises), 32'd4);
    chk("t3_drained", 32'(pending), 32'd0);

    // Saturation and overflow clear priority
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
    end
    chk("t4_sat", 32'(pending), 32'd3);
    chk("t4_ovf", 32'(overflow), 32'd1);
    step(1'b1, 1'b0, 1'b1);
    chk("t4_ovf_clr", 32'(overflow), 32'd0);
    step(1'b1, 1'b1, 1'b1);
    chk("t4_set_wins", 32'(overflow), 32'd1);
    idle(100);
    step(1'b1, 1'b0, 1'b1);

    // Event exactly at OFF exit
    step(1'b1, 1'b1, 1'b0);
    idle(19);
    step(1'b1, 1'b1, 1'b0);
    chk("t5_direct_on", 32'(led), 32'd1);
    chk("t5_pend0", 32'(pending), 32'd0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    idle(17);
    step(1'b1, 1'b1, 1'b0);
    chk("t5_cancel_led", 32'(led), 32'd1);
    chk("t5_cancel_pend", 32'(pending), 32'd1);
    idle(60);

    // Reset mid-pulse
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("t6_pre_pend", 32'(pending), 32'd2);
    step(1'b0, 1'b0, 1'b0);
    chk("t6_led", 32'(led), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_pend", 32'(pending), 32'd0);
    led_hi = 0;
    step(1'b1, 1'b1, 1'b0);
    idle(30);
    chk("t6_full_pulse", 32'(led_hi), 32'd12);

    // Random traffic against the model
    for (int i = 0; i < 700; i++) begin
      logic ein, clr, rn;
      ein = ($urandom_range(0, 3) == 0) ? ~event_in : event_in;
      clr = ($urandom_range(0, 15) == 0);
      rn  = ($urandom_range(0, 199) != 0);
      step(rn, ein, clr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
